sel_mux_pipe: RTL
=================

# sel_mux_pipe

Parametrised, registered N-way operand selector with a valid/ready handshake and a two-entry skid buffer. It is the pipelined successor to the combinational write-register and operand muxes. It sits between decode/forwarding logic and the next pipeline stage. Out-of-range selects are recorded in error state instead of silently holding the output.

## Interface
- WIDTH, 32: data width of each input and of the output.
- NUM_IN, 3: number of selectable inputs, 2..16.
- SEL_W, $clog2(NUM_IN): select width, derived and not overridden. A 1-bit minimum applies.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat. Driven from a register.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select for the current beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  WIDTH  selected data.
- out_sel  out  SEL_W  select value that produced out_data.
- sel_err  out  1  sticky flag: an illegal select (in_sel >= NUM_IN) has been accepted.
- err_count  out  8  count of illegal selects, saturating at 255.
- clr_err  in  1  synchronous clear of sel_err and err_count.

## Operation
- Accept: a beat is accepted when in_valid && in_ready. Output handoff occurs when out_valid && out_ready.
- Legal beat (in_sel < NUM_IN): the beat {in_data[in_sel], in_sel} enters the buffer.
- Illegal beat (in_sel >= NUM_IN):
  - The beat is consumed and no output beat is produced.
  - sel_err is set and err_count is incremented (saturating).
  - The buffer is unchanged.
- Storage is an output register (OR) plus a skid register (SK).
- State machine:
  - EMPTY: OR and SK are invalid.
  - ONE: OR is valid, SK is invalid.
  - FULL: OR and SK are valid.
- Transitions, where P = legal accept and D = output handoff:
  - EMPTY: P -> ONE (OR <= beat). Otherwise stay in EMPTY.
  - ONE, P && D: stay in ONE, OR <= beat.
  - ONE, P && !D: -> FULL, SK <= beat.
  - ONE, !P && D: -> EMPTY.
  - ONE, neither: hold.
  - FULL, D: -> ONE, OR <= SK.
  - FULL, no D: hold.
  - P cannot occur in FULL because in_ready = 0.
- in_ready = 1 in EMPTY and ONE, and 0 in FULL. It is a registered function of the next state.
- out_valid = 1 in ONE and FULL.
- out_data and out_sel always reflect OR. They are stable while out_valid && !out_ready.
- Beat order is preserved exactly, with no duplication or loss.
- Error logic:
  - clr_err zeroes sel_err and err_count.
  - If clr_err and an illegal accept occur in the same cycle, the result is sel_err = 1 and err_count = 1.
  - At 255, the count holds and sel_err stays 1.

## Timing
- Reset (asynchronous assert, synchronous-safe release) produces:
  - state EMPTY;
  - in_ready = 1, out_valid = 0;
  - out_data = 0, out_sel = 0;
  - sel_err = 0, err_count = 0.
  - SK contents are 0.
- Latency: a legal beat accepted at edge N is presented on out_data/out_valid after edge N (1 cycle).
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, two beats are accepted.
  - in_ready drops after the second acceptance edge.
  - in_ready rises again the cycle after the first handoff.
- No combinational path exists from out_ready to in_ready, or from in_* to out_*.
- Reset asserted mid-operation (ONE/FULL) discards all buffered beats immediately. No output beat is produced afterwards until a new accept.
- Error outputs update on the edge of the illegal accept, i.e. visible 1 cycle later.

## Test plan
- Reset: drive rst_n = 0 mid-stream in FULL -> in_ready = 1, out_valid = 0, out_data = 0, err_count = 0, without waiting for a clock edge.
- Single beat (NUM_IN = 3, WIDTH = 32):
  - in_data = {0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, in_sel = 2.
  - Required: out_data = 0xCCCC0002, out_sel = 2, out_valid one cycle after accept.
- Backpressure:
  - Hold out_ready = 0 and send sel 0 then sel 1 -> FULL, in_ready = 0.
  - Raise out_ready -> outputs 0xAAAA0000 then 0xBBBB0001 on consecutive cycles, in order.
  - in_ready = 1 after the first handoff.
- Streaming: out_ready = 1, 8 back-to-back beats cycling sel 0,1,2 -> 8 outputs on 8 consecutive cycles, in_ready constantly 1.
- Illegal select:
  - in_sel = 3 (NUM_IN = 3) -> no out_valid, sel_err = 1, err_count = 1.
  - A following legal beat passes normally.
  - 300 illegal beats -> err_count = 255.
- Clear collision: clr_err and an illegal accept in the same cycle with err_count = 7 -> sel_err = 1, err_count = 1. clr_err alone -> both 0.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// Registered N-way operand selector with valid/ready handshake and a two-entry
// skid buffer; illegal selects are consumed and counted instead of forwarded.
module sel_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    output logic [7:0]              err_count,
    input  logic                    clr_err
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // One extra bit so NUM_IN itself is representable when it is a power of two.
    localparam logic [SEL_W:0] NUM_IN_C = (SEL_W + 1)'(NUM_IN);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] or_data_r;
    logic [SEL_W-1:0] or_sel_r;
    logic [WIDTH-1:0] sk_data_r;
    logic [SEL_W-1:0] sk_sel_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             sel_err_r;
    logic [7:0]       err_count_r;

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_legal_s;
    logic             accept_s;
    logic             push_s;
    logic             illegal_s;
    logic             handoff_s;
    logic             or_load_beat_s;
    logic             or_load_sk_s;
    logic             sk_load_s;

    assign sel_legal_s = ({1'b0, in_sel} < NUM_IN_C);
    assign accept_s    = in_valid && in_ready_r;
    assign push_s      = accept_s && sel_legal_s;
    assign illegal_s   = accept_s && !sel_legal_s;
    assign handoff_s   = out_valid_r && out_ready;

    // Input word selection; only consumed when the select is legal.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data_s = in_data[k*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Buffer occupancy transitions and register load enables.
    always_comb begin
        state_nxt_s    = state_r;
        or_load_beat_s = 1'b0;
        or_load_sk_s   = 1'b0;
        sk_load_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s    = ST_ONE;
                    or_load_beat_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && handoff_s) begin
                    state_nxt_s    = ST_ONE;
                    or_load_beat_s = 1'b1;
                end else if (push_s) begin
                    state_nxt_s = ST_FULL;
                    sk_load_s   = 1'b1;
                end else if (handoff_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (handoff_s) begin
                    state_nxt_s  = ST_ONE;
                    or_load_sk_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, handshake flags and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            or_data_r   <= {WIDTH{1'b0}};
            or_sel_r    <= {SEL_W{1'b0}};
            sk_data_r   <= {WIDTH{1'b0}};
            sk_sel_r    <= {SEL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            if (or_load_beat_s) begin
                or_data_r <= sel_data_s;
                or_sel_r  <= in_sel;
            end else if (or_load_sk_s) begin
                or_data_r <= sk_data_r;
                or_sel_r  <= sk_sel_r;
            end else begin
                or_data_r <= or_data_r;
                or_sel_r  <= or_sel_r;
            end
            if (sk_load_s) begin
                sk_data_r <= sel_data_s;
                sk_sel_r  <= in_sel;
            end else begin
                sk_data_r <= sk_data_r;
                sk_sel_r  <= sk_sel_r;
            end
        end
    end

    // Sticky error flag and saturating counter; a same-cycle illegal beat wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r   <= 1'b0;
            err_count_r <= 8'd0;
        end else if (clr_err) begin
            if (illegal_s) begin
                sel_err_r   <= 1'b1;
                err_count_r <= 8'd1;
            end else begin
                sel_err_r   <= 1'b0;
                err_count_r <= 8'd0;
            end
        end else if (illegal_s) begin
            sel_err_r <= 1'b1;
            if (err_count_r != 8'd255) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            sel_err_r   <= sel_err_r;
            err_count_r <= err_count_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = or_data_r;
    assign out_sel   = or_sel_r;
    assign sel_err   = sel_err_r;
    assign err_count = err_count_r;

endmodule
